// File: rtl/credit_pkg.sv
// Shared types and helpers for the credit-flow transmit block.
package credit_pkg;

    // Flush handshake phases of the sender.
    typedef enum logic [1:0] {
        ACTIVE,
        DRAIN,
        DONE
    } credit_state_e;

    // Width needed to hold every count from 0 up to and including the credit total.
    function automatic int credit_cw(input int credits);
        return $clog2(credits + 1);
    endfunction

endpackage

// File: rtl/credit_counter.sv
// Saturating up/down credit counter with a sticky overflow flag.
// The count starts full (every remote slot free) and never exceeds CREDITS.
module credit_counter
    import credit_pkg::*;
#(
    parameter int CREDITS = 4,
    parameter int CW      = credit_cw(CREDITS)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          dec_i,
    input  logic          inc_i,
    output logic [CW-1:0] cnt_o,
    output logic          zero_o,
    output logic          full_o,
    output logic          ovf_o
);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          ovf_q, ovf_d;

    // Next count: a decrement and an increment together cancel; an increment at full saturates and flags overflow.
    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (inc_i && !dec_i) begin
            if (cnt_q == CW'(CREDITS)) begin
                ovf_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end else if (dec_i && !inc_i) begin
            if (cnt_q != '0) begin
                cnt_d = cnt_q - CW'(1);
            end
        end
    end

    // Count and sticky overflow registers; reset restores a full credit pool.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= CW'(CREDITS);
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign zero_o = (cnt_q == '0);
    assign full_o = (cnt_q == CW'(CREDITS));
    assign ovf_o  = ovf_q;

endmodule

// File: rtl/credit_sender.sv
// Transmit end of a credit-flow link: accepts ready/valid items, emits registered
// valid-only beats while credits remain, and offers a flush handshake that waits
// for every credit to come home. CREDITS must be at least 1.
module credit_sender
    import credit_pkg::*;
#(
    parameter type T       = logic,
    parameter int  CREDITS = 4,
    parameter int  CW      = credit_cw(CREDITS)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  T              in_bits_i,
    output logic          out_valid_o,
    output T              out_bits_o,
    input  logic          credit_i,
    input  logic          flush_req_i,
    output logic          flush_done_o,
    output logic [CW-1:0] credits_o,
    output logic          err_o
);

    credit_state_e state_q, state_d;
    logic          out_valid_q, out_valid_d;
    T              out_bits_q, out_bits_d;

    logic [CW-1:0] cnt;
    logic          cnt_zero;
    logic          cnt_full;
    logic          cnt_ovf;
    logic          fire;
    logic          drained_next;

    // Ready comes from registered state only, so upstream never sees a path from credit_i.
    assign in_ready_o = (state_q == ACTIVE) && !cnt_zero;
    assign fire       = in_valid_i && in_ready_o;

    credit_counter #(
        .CREDITS (CREDITS),
        .CW      (CW)
    ) u_counter (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .dec_i  (fire),
        .inc_i  (credit_i),
        .cnt_o  (cnt),
        .zero_o (cnt_zero),
        .full_o (cnt_full),
        .ovf_o  (cnt_ovf)
    );

    // The pool will be full next cycle if it is full now and nothing leaves, or the last credit arrives now.
    always_comb begin
        drained_next = 1'b0;
        if (!fire) begin
            drained_next = cnt_full || ((cnt == CW'(CREDITS - 1)) && credit_i);
        end else if (credit_i) begin
            drained_next = cnt_full;
        end
    end

    // Flush FSM and beat register: a beat follows its accept by one cycle and the payload holds otherwise.
    always_comb begin
        state_d     = state_q;
        out_valid_d = fire;
        out_bits_d  = out_bits_q;
        if (fire) begin
            out_bits_d = in_bits_i;
        end
        case (state_q)
            ACTIVE: begin
                if (flush_req_i) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (drained_next) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = ACTIVE;
            end
            default: begin
                state_d = ACTIVE;
            end
        endcase
    end

    // State and output registers; reset abandons any flush in progress without a done pulse.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ACTIVE;
            out_valid_q <= 1'b0;
            out_bits_q  <= T'(0);
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_bits_q  <= out_bits_d;
        end
    end

    assign out_valid_o  = out_valid_q;
    assign out_bits_o   = out_bits_q;
    assign flush_done_o = (state_q == DONE);
    assign credits_o    = cnt;
    assign err_o        = cnt_ovf;

endmodule
